// File: rtl/wb_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int TMO_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unacknowledged strobe cycles of the granted master and
// fires a forced termination, latching a sticky timeout flag.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic stb,
  input  logic ack,
  input  logic tmo_clr,
  output logic fire,
  output logic tmo_flag
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  // A late ack in the limit cycle wins over the forced termination.
  assign fire     = active & stb & ~ack & (cnt_q == LIMIT);
  assign tmo_flag = flag_q;

  // Every grant is preceded by an IDLE cycle (active=0), so the count
  // always starts from zero on entering a grant.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!active || !stb || ack || fire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (tmo_clr) begin
      flag_d = 1'b0;
    end
    if (fire) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-requester Wishbone arbiter: cycle-long grants, round-robin on contention,
// purely combinational routing from registered grant state, watchdog termination.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADR_W    = 32,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  TMO_DATA = '0,
  parameter int                 PRIO0    = 1
) (
  input  logic                clk,
  input  logic                reset,
  // requester 0
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADR_W-1:0]    m0_adr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_dat_m,
  output logic [DATA_W-1:0]   m0_dat_s,
  output logic                m0_ack,
  // requester 1
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADR_W-1:0]    m1_adr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_dat_m,
  output logic [DATA_W-1:0]   m1_dat_s,
  output logic                m1_ack,
  // shared slave bus
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADR_W-1:0]    s_adr,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [DATA_W-1:0]   s_dat_m,
  input  logic [DATA_W-1:0]   s_dat_s,
  input  logic                s_ack,
  // status
  output logic                tmo_flag,
  input  logic                tmo_clr,
  output logic [1:0]          gnt
);

  arb_state_t state_q, state_d;
  logic       rr_q, rr_d;   // 1: m0 preferred on contention
  logic       gm_stb;
  logic       tmo_fire;

  assign gnt    = {state_q == ARB_GNT1, state_q == ARB_GNT0};
  assign gm_stb = (state_q == ARB_GNT0) ? m0_stb :
                  (state_q == ARB_GNT1) ? m1_stb : 1'b0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = rr_q ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cyc) begin
          state_d = ARB_GNT0;
        end else if (m1_cyc) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc) begin
          state_d = ARB_IDLE;
          rr_d    = 1'b0;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc) begin
          state_d = ARB_IDLE;
          rr_d    = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      rr_q    <= (PRIO0 != 0);
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Routing: the non-granted master sees zero data and no ack; a timeout
  // substitutes TMO_DATA/ack and withholds the strobe for that one cycle.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_m  = '0;
    m0_ack   = 1'b0;
    m0_dat_s = '0;
    m1_ack   = 1'b0;
    m1_dat_s = '0;
    unique case (state_q)
      ARB_GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb & ~tmo_fire;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_m  = m0_dat_m;
        m0_ack   = s_ack | tmo_fire;
        m0_dat_s = tmo_fire ? TMO_DATA : s_dat_s;
      end
      ARB_GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb & ~tmo_fire;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_m  = m1_dat_m;
        m1_ack   = s_ack | tmo_fire;
        m1_dat_s = tmo_fire ? TMO_DATA : s_dat_s;
      end
      default: ;
    endcase
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q != ARB_IDLE),
    .stb      (gm_stb),
    .ack      (s_ack),
    .tmo_clr  (tmo_clr),
    .fire     (tmo_fire),
    .tmo_flag (tmo_flag)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed, table-driven bench for wb_arbiter2 (TIMEOUT=8, PRIO0=1).
module tb_wb_arbiter2;

  localparam logic [31:0] D  = 32'h1234_5678;
  localparam logic [31:0] T  = 32'hDEAD_0BAD;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'hA0A0_A0A0;
  localparam logic [31:0] W1 = 32'hB1B1_B1B1;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_dat_m, m0_dat_s;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_dat_m, m1_dat_s;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_dat_m, s_dat_s;
  logic [3:0]  s_sel;
  logic        tmo_flag, tmo_clr;
  logic [1:0]  gnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .DATA_W(32), .ADR_W(32), .TIMEOUT(8), .TMO_DATA(T), .PRIO0(1)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_m(m0_dat_m), .m0_dat_s(m0_dat_s), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_m(m1_dat_m), .m1_dat_s(m1_dat_s), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack),
    .tmo_flag(tmo_flag), .tmo_clr(tmo_clr), .gnt(gnt)
  );

  typedef struct {
    logic [6:0]  in;   // {rst, c0, s0, c1, s1, ack, clr}
    logic [1:0]  gnt;
    logic [4:0]  out;  // {s_cyc, s_stb, m0_ack, m1_ack, tmo_flag}
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [6:0] in, input logic [1:0] g, input logic [4:0] o,
                     input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.in = in; v.gnt = g; v.out = o; v.d0 = d0; v.d1 = d1;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic drive(input logic [6:0] in);
    {reset, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, tmo_clr} = in;
  endtask

  initial begin
    logic [31:0] ea, ew, em, es;
    m0_we = 1'b0; m0_adr = A0; m0_sel = S0; m0_dat_m = W0;
    m1_we = 1'b1; m1_adr = A1; m1_sel = S1; m1_dat_m = W1;
    s_dat_s = D;
    drive(7'b1_00_00_0_0);

    // test 1: m0 single read, two wait states
    add(7'b0_11_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_00_0_0, 2'b01, 5'b11_00_0, D, Z);
    add(7'b0_11_00_0_0, 2'b01, 5'b11_00_0, D, Z);
    add(7'b0_11_00_1_0, 2'b01, 5'b11_10_0, D, Z);
    add(7'b0_00_00_0_0, 2'b01, 5'b00_00_0, D, Z);
    add(7'b1_00_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    // test 2: contention, m0 first after reset, then m1 wins the repeat
    add(7'b0_11_11_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_11_1_0, 2'b01, 5'b11_10_0, D, Z);
    add(7'b0_00_11_0_0, 2'b01, 5'b00_00_0, D, Z);
    add(7'b0_11_11_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_11_1_0, 2'b10, 5'b11_01_0, Z, D);
    add(7'b0_11_00_0_0, 2'b10, 5'b00_00_0, Z, D);
    add(7'b0_11_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_00_1_0, 2'b01, 5'b11_10_0, D, Z);
    add(7'b0_00_00_0_0, 2'b01, 5'b00_00_0, D, Z);
    add(7'b0_00_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    // test 3: m1 four-beat cycle, m0 waits
    add(7'b0_00_11_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_11_1_0, 2'b10, 5'b11_01_0, Z, D);
    add(7'b0_11_10_0_0, 2'b10, 5'b10_00_0, Z, D);
    for (int i = 0; i < 3; i++) add(7'b0_11_11_1_0, 2'b10, 5'b11_01_0, Z, D);
    add(7'b0_11_00_0_0, 2'b10, 5'b00_00_0, Z, D);
    add(7'b0_11_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    add(7'b0_11_00_1_0, 2'b01, 5'b11_10_0, D, Z);
    add(7'b0_00_00_0_0, 2'b01, 5'b00_00_0, D, Z);
    add(7'b0_00_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    // test 4: slave never acks, forced termination in 8th strobe cycle
    add(7'b0_11_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    for (int i = 0; i < 7; i++) add(7'b0_11_00_0_0, 2'b01, 5'b11_00_0, D, Z);
    add(7'b0_11_00_0_0, 2'b01, 5'b10_10_0, T, Z);
    add(7'b0_00_00_0_0, 2'b01, 5'b00_00_1, D, Z);
    add(7'b0_00_00_0_0, 2'b00, 5'b00_00_1, Z, Z);
    add(7'b0_00_00_0_0, 2'b00, 5'b00_00_1, Z, Z);
    add(7'b0_00_00_0_1, 2'b00, 5'b00_00_1, Z, Z);
    add(7'b0_11_00_0_0, 2'b00, 5'b00_00_0, Z, Z);
    // test 5: ack lands in the exact timeout cycle
    for (int i = 0; i < 7; i++) add(7'b0_11_00_0_0, 2'b01, 5'b11_00_0, D, Z);
    add(7'b0_11_00_1_0, 2'b01, 5'b11_10_0, D, Z);
    add(7'b0_00_00_0_0, 2'b01, 5'b00_00_0, D, Z);
    add(7'b0_00_00_0_0, 2'b00, 5'b00_00_0, Z, Z);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst gnt", gnt, 2'b00);
    chk("rst s_cyc", s_cyc, 1'b0);
    chk("rst s_stb", s_stb, 1'b0);
    chk("rst m0_ack", m0_ack, 1'b0);
    chk("rst m1_ack", m1_ack, 1'b0);
    chk("rst tmo_flag", tmo_flag, 1'b0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].in);
      #1;
      ea = (vq[i].gnt == 2'b01) ? A0 : (vq[i].gnt == 2'b10) ? A1 : Z;
      ew = (vq[i].gnt == 2'b10) ? 32'd1 : 32'd0;
      em = (vq[i].gnt == 2'b01) ? W0 : (vq[i].gnt == 2'b10) ? W1 : Z;
      es = (vq[i].gnt == 2'b01) ? {28'd0, S0} : (vq[i].gnt == 2'b10) ? {28'd0, S1} : Z;
      chk($sformatf("r%0d gnt", i), gnt, vq[i].gnt);
      chk($sformatf("r%0d s_cyc", i), s_cyc, vq[i].out[4]);
      chk($sformatf("r%0d s_stb", i), s_stb, vq[i].out[3]);
      chk($sformatf("r%0d m0_ack", i), m0_ack, vq[i].out[2]);
      chk($sformatf("r%0d m1_ack", i), m1_ack, vq[i].out[1]);
      chk($sformatf("r%0d tmo_flag", i), tmo_flag, vq[i].out[0]);
      chk($sformatf("r%0d m0_dat_s", i), m0_dat_s, vq[i].d0);
      chk($sformatf("r%0d m1_dat_s", i), m1_dat_s, vq[i].d1);
      chk($sformatf("r%0d s_adr", i), s_adr, ea);
      chk($sformatf("r%0d s_we", i), s_we, ew);
      chk($sformatf("r%0d s_dat_m", i), s_dat_m, em);
      chk($sformatf("r%0d s_sel", i), s_sel, es);
    end

    // set beats clear when a timeout coincides with tmo_clr
    @(negedge clk);
    drive(7'b0_11_00_0_0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tmo_clr = (i == 7);
      #1;
      if (i == 7) chk("setwin fire ack", m0_ack, 1'b1);
    end
    @(negedge clk);
    drive(7'b0_00_00_0_1);
    #1;
    chk("setwin flag held", tmo_flag, 1'b1);
    @(negedge clk);
    drive(7'b0_00_00_0_0);
    #1;
    chk("setwin flag cleared", tmo_flag, 1'b0);

    // reset during GNT1 with strobe high
    drive(7'b0_00_11_0_0);
    @(negedge clk);
    #1;
    chk("rstmid gnt before", gnt, 2'b10);
    chk("rstmid s_stb before", s_stb, 1'b1);
    drive(7'b1_00_11_0_0);
    @(negedge clk);
    drive(7'b0_11_11_0_0);
    #1;
    chk("rstmid gnt", gnt, 2'b00);
    chk("rstmid s_cyc", s_cyc, 1'b0);
    chk("rstmid m1_ack", m1_ack, 1'b0);
    chk("rstmid m0_ack", m0_ack, 1'b0);
    @(negedge clk);
    drive(7'b0_11_11_1_0);
    #1;
    chk("post-rst gnt", gnt, 2'b01);
    chk("post-rst s_cyc", s_cyc, 1'b1);
    chk("post-rst m0_ack", m0_ack, 1'b1);
    chk("post-rst m1_ack", m1_ack, 1'b0);
    @(negedge clk);
    drive(7'b0_00_00_0_0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
